// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for a multi-cycle MIPS datapath with one shared memory.
//   Each instruction is sequenced through fetch, decode, execute, memory and
//   writeback cycles. Memory accesses use a req/ready handshake, so any
//   memory cycle may be stretched. 'mult' is held in the ALU for MULT_CYCLES
//   cycles.
//
// Parameters
//   ALUOP_W      width of alu_op (>= 3)
//   MULT_CYCLES  total ALU cycles spent on 'mult' (1..16)
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   opcode, func         IR[31:26] / IR[5:0], sampled only in DECODE
//   mem_ready            memory completes the current request this cycle
//   mem_req, mem_we      memory request / write qualifier
//   iord                 address select (0 = PC, 1 = ALUOut)
//   ir_write             latch the fetched instruction
//   pc_write             unconditional PC update
//   pc_write_cond        PC update when the ALU reports zero
//   pc_src               0 ALU, 1 ALUOut, 2 jump target, 3 exception vector
//   alu_src_a            0 PC, 1 rs
//   alu_src_b            0 rt, 1 const 4, 2 extended imm, 3 imm<<2
//   alu_op               0 AND, 1 OR, 2 ADD, 3 ADDU, 4 MULT, 5 SUB
//   reg_dst, mem_to_reg  register write address / data selects
//   reg_write            register file write enable
//   illegal              one-cycle pulse on an undecodable instruction
//   state                current state code (debug)

module multicycle_control #(
  parameter int ALUOP_W     = 3,
  parameter int MULT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               illegal,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REXEC   = 4'd7,
    S_MULWAIT = 4'd8,
    S_ALUWB   = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_BRANCH  = 4'd12,
    S_JUMP    = 4'd13,
    S_ILLEGAL = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;

  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_MULT = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(5);

  // MULWAIT lasts MULT_CYCLES-1 cycles: the counter is loaded with
  // MULT_CYCLES-2 and the state exits on the cycle it reads zero.
  localparam logic [3:0] MUL_LOAD = (MULT_CYCLES > 1) ? 4'(MULT_CYCLES - 2) : 4'd0;

  state_t     state_reg;
  logic [5:0] opcode_reg;
  logic [5:0] func_reg;
  logic [3:0] mul_cnt_reg;

  function automatic logic [ALUOP_W-1:0] rtype_alu(input logic [5:0] f);
    case (f)
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_ADD:  return ALU_ADD;
      FN_ADDU: return ALU_ADDU;
      FN_MULT: return ALU_MULT;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] itype_alu(input logic [5:0] op);
    case (op)
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_ADDI:  return ALU_ADD;
      OP_ADDIU: return ALU_ADDU;
      default:  return ALU_ADD;
    endcase
  endfunction

  // Next-state sequencing. The instruction fields are captured on the
  // DECODE edge so later IR changes cannot disturb the instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      opcode_reg  <= '0;
      func_reg    <= '0;
      mul_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE:  state_reg <= S_FETCH;
        S_FETCH: if (mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          opcode_reg <= opcode;
          func_reg   <= func;
          case (opcode)
            OP_RTYPE:                          state_reg <= S_REXEC;
            OP_LW, OP_SW:                      state_reg <= S_MEMADR;
            OP_ANDI, OP_ORI, OP_ADDI, OP_ADDIU: state_reg <= S_IEXEC;
            OP_BEQ:                            state_reg <= S_BRANCH;
            OP_J:                              state_reg <= S_JUMP;
            default:                           state_reg <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: state_reg <= (opcode_reg == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_reg <= S_MEMWB;
        S_MEMWB:  state_reg <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_reg <= S_FETCH;
        S_REXEC: begin
          case (func_reg)
            FN_AND, FN_OR, FN_ADD, FN_ADDU: state_reg <= S_ALUWB;
            FN_MULT: begin
              if (MULT_CYCLES > 1) begin
                mul_cnt_reg <= MUL_LOAD;
                state_reg   <= S_MULWAIT;
              end else begin
                state_reg <= S_ALUWB;
              end
            end
            default: state_reg <= S_ILLEGAL;
          endcase
        end
        S_MULWAIT: begin
          if (mul_cnt_reg == 4'd0) state_reg <= S_ALUWB;
          else                     mul_cnt_reg <= mul_cnt_reg - 4'd1;
        end
        S_ALUWB:   state_reg <= S_FETCH;
        S_IEXEC:   state_reg <= S_IWB;
        S_IWB:     state_reg <= S_FETCH;
        S_BRANCH:  state_reg <= S_FETCH;
        S_JUMP:    state_reg <= S_FETCH;
        S_ILLEGAL: state_reg <= S_FETCH;
        default:   state_reg <= S_IDLE;
      endcase
    end
  end

  // Moore output decode. ir_write/pc_write in FETCH are the only outputs
  // that depend on an input: they fire in the cycle the fetch completes.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = '0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = rtype_alu(func_reg);
      end
      S_MULWAIT: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_MULT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = itype_alu(opcode_reg);
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
      end
      S_ILLEGAL: begin
        illegal  = 1'b1;
        pc_write = 1'b1;
        pc_src   = 2'd3;
      end
      default: ;
    endcase
  end

  assign state = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: reset checks, a table of instructions with
// hand-computed cycle counts, reset during a store, randomized instruction
// streams against a trace model, and a MULT_CYCLES=1 instance.

module tb_multicycle_control;

  localparam int MC = 4;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3,
                 P_MEMRD = 4, P_MEMWB = 5, P_MEMWR = 6, P_REXEC = 7,
                 P_MULWAIT = 8, P_ALUWB = 9, P_IEXEC = 10, P_IWB = 11,
                 P_BRANCH = 12, P_JUMP = 13, P_ILLEGAL = 14;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, illegal;
  } out_t;

  typedef struct {
    bit   drive;
    bit   rdy;
    out_t exp;
  } step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int fw, mw, cyc, ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, mem_ready;
  logic [5:0] opcode, func;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b;
  logic alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
  logic [2:0] alu_op;
  logic [3:0] state;
  out_t got;

  logic rst1_n, mem_ready1;
  logic [5:0] opcode1, func1;
  logic mem_req1, mem_we1, iord1, ir_write1, pc_write1, pc_write_cond1;
  logic [1:0] pc_src1, alu_src_b1;
  logic alu_src_a1, reg_dst1, mem_to_reg1, reg_write1, illegal1;
  logic [2:0] alu_op1;
  logic [3:0] state1;
  out_t got1;

  int checks = 0;
  int passed = 0;
  step_t tr[$];
  vec_t vecs[14];

  initial forever #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(3), .MULT_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .state(state)
  );

  multicycle_control #(.ALUOP_W(3), .MULT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .opcode(opcode1), .func(func1), .mem_ready(mem_ready1),
    .mem_req(mem_req1), .mem_we(mem_we1), .iord(iord1), .ir_write(ir_write1),
    .pc_write(pc_write1), .pc_write_cond(pc_write_cond1), .pc_src(pc_src1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
    .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .reg_write(reg_write1),
    .illegal(illegal1), .state(state1)
  );

  assign got  = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                 pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                 reg_write, illegal};
  assign got1 = {state1, mem_req1, mem_we1, iord1, ir_write1, pc_write1, pc_write_cond1,
                 pc_src1, alu_src_a1, alu_src_b1, alu_op1, reg_dst1, mem_to_reg1,
                 reg_write1, illegal1};

  // Expected control word for one cycle of a given phase, from the state table.
  function automatic out_t ph(input int s, input bit rdy, input logic [2:0] aop);
    out_t o;
    o = '0;
    o.state = 4'(s);
    case (s)
      P_FETCH:   begin o.mem_req = 1; o.alu_src_b = 2'd1; o.alu_op = 3'd2;
                       o.ir_write = rdy; o.pc_write = rdy; end
      P_DECODE:  begin o.alu_src_b = 2'd3; o.alu_op = 3'd2; end
      P_MEMADR:  begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = 3'd2; end
      P_MEMRD:   begin o.mem_req = 1; o.iord = 1; end
      P_MEMWB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
      P_MEMWR:   begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
      P_REXEC:   begin o.alu_src_a = 1; o.alu_op = aop; end
      P_MULWAIT: begin o.alu_src_a = 1; o.alu_op = 3'd4; end
      P_ALUWB:   begin o.reg_write = 1; o.reg_dst = 1; end
      P_IEXEC:   begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = aop; end
      P_IWB:     o.reg_write = 1;
      P_BRANCH:  begin o.alu_src_a = 1; o.alu_op = 3'd5; o.pc_write_cond = 1; o.pc_src = 2'd1; end
      P_JUMP:    begin o.pc_write = 1; o.pc_src = 2'd2; end
      P_ILLEGAL: begin o.illegal = 1; o.pc_write = 1; o.pc_src = 2'd3; end
      default:   ;
    endcase
    return o;
  endfunction

  function automatic void add(input int s, input bit drive, input bit rdy, input logic [2:0] aop);
    step_t st;
    st.drive = drive;
    st.rdy   = rdy;
    st.exp   = ph(s, rdy, aop);
    tr.push_back(st);
  endfunction

  // Builds the full expected cycle trace of one instruction from its class.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    int a;
    tr.delete();
    repeat (fw) add(P_FETCH, 1, 0, 0);
    add(P_FETCH, 1, 1, 0);
    add(P_DECODE, 0, 0, 0);
    case (op)
      6'd0: begin
        case (fn)
          6'd36: a = 0;
          6'd37: a = 1;
          6'd32: a = 2;
          6'd33: a = 3;
          6'd24: a = 4;
          default: a = -1;
        endcase
        if (a < 0) begin
          add(P_REXEC, 0, 0, 3'd0);
          add(P_ILLEGAL, 0, 0, 0);
        end else begin
          add(P_REXEC, 0, 0, 3'(a));
          if (fn == 6'd24) repeat (MC - 1) add(P_MULWAIT, 0, 0, 3'd4);
          add(P_ALUWB, 0, 0, 0);
        end
      end
      6'd35: begin
        add(P_MEMADR, 0, 0, 0);
        repeat (mw) add(P_MEMRD, 1, 0, 0);
        add(P_MEMRD, 1, 1, 0);
        add(P_MEMWB, 0, 0, 0);
      end
      6'd43: begin
        add(P_MEMADR, 0, 0, 0);
        repeat (mw) add(P_MEMWR, 1, 0, 0);
        add(P_MEMWR, 1, 1, 0);
      end
      6'd12: begin add(P_IEXEC, 0, 0, 3'd0); add(P_IWB, 0, 0, 0); end
      6'd13: begin add(P_IEXEC, 0, 0, 3'd1); add(P_IWB, 0, 0, 0); end
      6'd8:  begin add(P_IEXEC, 0, 0, 3'd2); add(P_IWB, 0, 0, 0); end
      6'd9:  begin add(P_IEXEC, 0, 0, 3'd3); add(P_IWB, 0, 0, 0); end
      6'd4:  add(P_BRANCH, 0, 0, 0);
      6'd2:  add(P_JUMP, 0, 0, 0);
      default: add(P_ILLEGAL, 0, 0, 0);
    endcase
  endfunction

  function automatic void check_out(input string name, input int idx, input out_t g, input out_t e);
    checks++;
    if (g === e) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, g, e);
  endfunction

  function automatic void check_int(input string name, input int idx, input int g, input int e);
    checks++;
    if (g == e) passed++;
    else $display("FAIL %s item %0d: got %0d expected %0d", name, idx, g, e);
  endfunction

  // Runs one instruction starting at posedge+1 of a FETCH cycle; compares
  // every cycle mid-period. With scramble, the IR changes after DECODE.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input bit scramble, input string name);
    build(op, fn, fw, mw);
    opcode = op;
    func   = fn;
    for (int i = 0; i < tr.size(); i++) begin
      mem_ready = tr[i].drive ? tr[i].rdy : 1'($urandom);
      if (scramble && i > fw + 1) begin
        opcode = 6'($urandom);
        func   = 6'($urandom);
      end
      #4;
      check_out(name, i, got, tr[i].exp);
      @(posedge clk); #1;
    end
  endtask

  // Measures cycles from FETCH to the next FETCH, answering the handshake.
  task automatic measure(input vec_t v, input int idx);
    int cyc, ill, fw, mw;
    bit left, done;
    opcode = v.op; func = v.fn; fw = v.fw; mw = v.mw;
    cyc = 0; ill = 0; left = 0; done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (left && state == 4'd1) done = 1;
      else begin
        if (state != 4'd1) left = 1;
        if (mem_req) begin
          if (state == 4'd1 && fw > 0) begin mem_ready = 0; fw--; end
          else if (state != 4'd1 && mw > 0) begin mem_ready = 0; mw--; end
          else mem_ready = 1;
        end else mem_ready = 1'($urandom);
        #4;
        if (illegal) ill++;
        cyc++;
        @(posedge clk); #1;
      end
    end
    check_int("tbl_done", idx, int'(done), 1);
    check_int("tbl_cycles", idx, cyc, v.cyc);
    check_int("tbl_illegal", idx, ill, v.ill);
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    out_t e1 [5];

    rst_n = 0; rst1_n = 0; mem_ready = 1; mem_ready1 = 1;
    opcode = 0; func = 0; opcode1 = 0; func1 = 0;

    // Reset: everything 0 even with mem_ready high.
    #2;
    check_out("reset_async", 0, got, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #4;
      check_out("reset_hold", i, got, '0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    #3;
    check_out("release_idle", 0, got, ph(P_IDLE, 0, 0));
    @(posedge clk); #1;

    // Table: {op, fn, fetch waits, mem waits, cycles, illegal pulses}.
    vecs[0]  = '{6'd0,  6'd32, 0, 0, 4, 0};
    vecs[1]  = '{6'd0,  6'd36, 1, 0, 5, 0};
    vecs[2]  = '{6'd0,  6'd37, 0, 0, 4, 0};
    vecs[3]  = '{6'd0,  6'd33, 0, 0, 4, 0};
    vecs[4]  = '{6'd0,  6'd24, 0, 0, 7, 0};
    vecs[5]  = '{6'd35, 6'd0,  0, 2, 7, 0};
    vecs[6]  = '{6'd43, 6'd0,  1, 1, 6, 0};
    vecs[7]  = '{6'd12, 6'd0,  0, 0, 4, 0};
    vecs[8]  = '{6'd9,  6'd0,  2, 0, 6, 0};
    vecs[9]  = '{6'd4,  6'd0,  0, 0, 3, 0};
    vecs[10] = '{6'd2,  6'd0,  0, 0, 3, 0};
    vecs[11] = '{6'd63, 6'd0,  0, 0, 3, 1};
    vecs[12] = '{6'd0,  6'd7,  0, 0, 4, 1};
    vecs[13] = '{6'd13, 6'd0,  0, 3, 4, 0};
    foreach (vecs[i]) measure(vecs[i], i);

    // Directed traces of the main corner cases.
    run_instr(6'd0,  6'd32, 0, 0, 0, "add");
    run_instr(6'd35, 6'd0,  0, 2, 0, "lw_wait2");
    run_instr(6'd0,  6'd24, 0, 0, 1, "mult4");
    run_instr(6'd4,  6'd0,  0, 0, 0, "beq");
    run_instr(6'd2,  6'd0,  0, 0, 0, "j");
    run_instr(6'd63, 6'd0,  0, 0, 0, "ill_op");
    run_instr(6'd0,  6'd7,  0, 0, 0, "ill_fn");

    // Reset in the middle of a stalled sw.
    opcode = 6'd43; func = 0; mem_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 0;
    #3;
    check_out("sw_memwr", 0, got, ph(P_MEMWR, 0, 0));
    rst_n = 0;
    #1;
    check_out("sw_reset_async", 0, got, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom);
      #3;
      check_out("sw_reset_hold", i, got, '0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    #3;
    check_out("sw_release_idle", 0, got, ph(P_IDLE, 0, 0));
    @(posedge clk); #1;
    run_instr(6'd4, 6'd0, 0, 0, 0, "after_abort");

    // Randomized instruction stream.
    ops = '{6'd0, 6'd35, 6'd43, 6'd12, 6'd13, 6'd8, 6'd9, 6'd4, 6'd2, 6'd0};
    fns = '{6'd36, 6'd37, 6'd32, 6'd33, 6'd24, 6'd0};
    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 5)];
      if (fn == 6'd0) fn = 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom), "random");
    end

    // MULT_CYCLES = 1: REXEC goes straight to ALUWB.
    e1[0] = ph(P_FETCH, 1, 0);
    e1[1] = ph(P_DECODE, 0, 0);
    e1[2] = ph(P_REXEC, 0, 3'd4);
    e1[3] = ph(P_ALUWB, 0, 0);
    e1[4] = ph(P_FETCH, 1, 0);
    @(posedge clk); #1;
    rst1_n = 1; opcode1 = 6'd0; func1 = 6'd24; mem_ready1 = 1;
    #3;
    check_out("mult1_idle", 0, got1, ph(P_IDLE, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #4;
      check_out("mult1", i, got1, e1[i]);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle MIPS control decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives the shared-memory datapath's muxes and write enables. It handles variable-latency memory through a req/ready handshake and runs a parametrised multi-cycle multiply. It sits between the instruction register (opcode/funct) and the datapath, memory port and PC.

## Interface
- `ALUOP_W`, default 3: width of `alu_op`; must be ≥3.
- `MULT_CYCLES`, default 4: total ALU cycles for `mult`; legal range 1..16.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  6  IR[31:26]; sampled only in DECODE.
- `func`  in  6  IR[5:0]; sampled only in DECODE.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write when `mem_req`=1.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  latch instruction.
- `pc_write`  out  1  unconditional PC update.
- `pc_write_cond`  out  1  PC update if ALU zero.
- `pc_src`  out  2  0 = ALU, 1 = ALUOut, 2 = jump target, 3 = exception vector.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  0 = rt, 1 = const 4, 2 = sign/zero-ext imm, 3 = imm<<2.
- `alu_op`  out  ALUOP_W  0 AND, 1 OR, 2 ADD, 3 ADDU, 4 MULT, 5 SUB.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `state`  out  4  current state code, for debug.

## Operation
- States, with the outputs that are not 0:
  - IDLE=0: all outputs 0; goes to FETCH.
  - FETCH=1: `mem_req`, `alu_src_b`=1, `alu_op`=ADD. `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
  - DECODE=2: `alu_src_b`=3, ADD. Dispatches on `opcode`: 0 to REXEC; 35/43 to MEMADR; 12/13/8/9 to IEXEC; 4 to BRANCH; 2 to JUMP; anything else to ILLEGAL.
  - MEMADR=3: `alu_src_a`=1, `alu_src_b`=2, ADD. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD=4: `mem_req`, `iord`. Waits for `mem_ready`, then goes to MEMWB.
  - MEMWB=5: `reg_write`, `mem_to_reg`. Goes to FETCH.
  - MEMWR=6: `mem_req`, `mem_we`, `iord`. Waits for `mem_ready`, then goes to FETCH.
  - REXEC=7: `alu_src_a`=1, `alu_src_b`=0. `alu_op` from `func`: 36 AND, 37 OR, 32 ADD, 33 ADDU, 24 MULT. Any other `func` goes to ILLEGAL. MULT goes to MULWAIT if `MULT_CYCLES`>1, else to ALUWB. All other funcs go to ALUWB.
  - MULWAIT=8: same mux settings as REXEC, `alu_op`=MULT held. Stays exactly `MULT_CYCLES`−1 cycles via a down-counter, then goes to ALUWB.
  - ALUWB=9: `reg_write`, `reg_dst`. Goes to FETCH.
  - IEXEC=10: `alu_src_a`=1, `alu_src_b`=2. `alu_op`: 12 AND, 13 OR, 8 ADD, 9 ADDU. Goes to IWB.
  - IWB=11: `reg_write`. Goes to FETCH.
  - BRANCH=12: `alu_src_a`=1, `alu_op`=SUB, `pc_write_cond`, `pc_src`=1. Goes to FETCH.
  - JUMP=13: `pc_write`, `pc_src`=2. Goes to FETCH.
  - ILLEGAL=14: `illegal`, `pc_write`, `pc_src`=3. Goes to FETCH.
- Unused state code 15 goes to IDLE next cycle, with all outputs 0.
- Opcode/funct decode is latched into internal registers at the DECODE edge. IR changes after DECODE have no effect on the instruction in flight.
- `alu_op` codes are zero-extended to `ALUOP_W`.
- Multiply counter: width 4. Loaded with `MULT_CYCLES`−2 on the REXEC→MULWAIT edge. MULWAIT exits when the counter is 0.

## Timing
- While `rst_n`=0, state is IDLE and every output is 0, immediately (asynchronous). The first FETCH is on the first clock edge after deassertion.
- All outputs are Moore, decoded from the state register. The only exceptions are `ir_write` and `pc_write` in FETCH, which are gated combinationally by `mem_ready`.
- Handshake:
  - `mem_req`, `mem_we` and `iord` stay stable until the cycle in which `mem_ready`=1.
  - A request completes on that edge. `mem_req` may drop the next cycle or be reasserted for a new access.
  - `mem_ready` is ignored whenever `mem_req`=0.
- Cycle counts with zero-wait memory (`mem_ready` held at 1):
  - R-type: 4; mult: 3+`MULT_CYCLES`.
  - lw: 5; sw: 4.
  - I-type ALU: 4.
  - beq, j, illegal: 3.
- Each memory wait cycle adds 1 cycle.
- Reset mid-instruction aborts it with no partial writeback. Any `reg_write` or `pc_write` that was pending is dropped.

## Test plan
- Reset with `rst_n`=0 held 3 cycles during MEMWR: all outputs are 0 during reset; IDLE then FETCH after release; `mem_we` never seen again for the aborted sw.
- `opcode`=0, `func`=32 with zero-wait memory: states 1,2,7,9 with `alu_op`=2 in REXEC; `reg_write`=1 and `reg_dst`=1 only in cycle 4.
- `opcode`=35 with `mem_ready` low for 2 cycles in MEMRD: `mem_req`=1 and `iord`=1 held 3 cycles; MEMWB has `mem_to_reg`=1 and `reg_write`=1; 7 cycles total.
- `opcode`=0, `func`=24 with `MULT_CYCLES`=4, then again with 1: `alu_op`=4 held 4 cycles, then ALUWB; with 1, REXEC goes directly to ALUWB (4 cycles total).
- `opcode`=4 then `opcode`=2: BRANCH has `pc_write_cond`=1, `pc_src`=1, `alu_op`=5; JUMP has `pc_write`=1, `pc_src`=2; each instruction takes 3 cycles.
- `opcode`=63, then `opcode`=0 with `func`=7: `illegal` is a 1-cycle pulse with `pc_src`=3 and `pc_write`=1 in each case, followed by FETCH.
